// File: rtl/m14k_rf_init_seq.sv
// Register-file write-port front end: clears every GPR of every shadow set after
// reset or on request, then passes pipeline W-stage writes straight through.
module m14k_rf_init_seq #(
    parameter int          NUM_SETS   = 16,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        gclk,
    input  logic        greset,
    input  logic        init_req,
    input  logic        w_rfwrite,
    input  logic [8:0]  w_dest,
    input  logic [31:0] w_wrdata,
    output logic        mpc_rfwrite_w,
    output logic [8:0]  mpc_dest_w,
    output logic [31:0] edp_wrdata_w,
    output logic        rf_init_done,
    output logic        init_stall,
    output logic        init_wr_err
);

    typedef enum logic [1:0] {
        RST,
        SWEEP,
        DONE
    } state_t;

    // NUM_SETS is a power of two, so NUM_SETS-1 doubles as the set-index mask.
    localparam logic [3:0] LAST_SET = 4'(NUM_SETS - 1);
    localparam logic [4:0] LAST_REG = 5'd31;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  set_cnt;
    logic [3:0]  set_nxt;
    logic [4:0]  reg_cnt;
    logic [4:0]  reg_nxt;
    logic        err_nxt;

    always_ff @(posedge gclk) begin
        if (greset) begin
            state       <= SWEEP;
            set_cnt     <= 4'd0;
            reg_cnt     <= 5'd1;
            init_wr_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            set_cnt     <= set_nxt;
            reg_cnt     <= reg_nxt;
            init_wr_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        set_nxt       = set_cnt;
        reg_nxt       = reg_cnt;
        err_nxt       = init_wr_err;
        mpc_rfwrite_w = 1'b0;
        mpc_dest_w    = 9'd0;
        edp_wrdata_w  = 32'd0;
        rf_init_done  = 1'b0;
        init_stall    = 1'b1;

        case (state)
            SWEEP: begin
                mpc_rfwrite_w = 1'b1;
                mpc_dest_w    = {set_cnt & LAST_SET, reg_cnt};
                edp_wrdata_w  = INIT_VALUE;
                // A pipeline write here would clobber the sweep; drop it and remember.
                if (w_rfwrite) begin
                    err_nxt = 1'b1;
                end
                if (reg_cnt == LAST_REG) begin
                    reg_nxt = 5'd1;
                    if (set_cnt == LAST_SET) begin
                        state_nxt = DONE;
                        set_nxt   = 4'd0;
                    end else begin
                        set_nxt = set_cnt + 4'd1;
                    end
                end else begin
                    reg_nxt = reg_cnt + 5'd1;
                end
            end
            DONE: begin
                mpc_rfwrite_w = w_rfwrite;
                mpc_dest_w    = w_dest;
                edp_wrdata_w  = w_wrdata;
                rf_init_done  = 1'b1;
                init_stall    = 1'b0;
                if (init_req) begin
                    state_nxt = SWEEP;
                    set_nxt   = 4'd0;
                    reg_nxt   = 5'd1;
                end
            end
            default: begin
                state_nxt = SWEEP;
                set_nxt   = 4'd0;
                reg_nxt   = 5'd1;
            end
        endcase

        if (greset) begin
            mpc_rfwrite_w = 1'b0;
            mpc_dest_w    = 9'd0;
            edp_wrdata_w  = 32'd0;
            rf_init_done  = 1'b0;
            init_stall    = 1'b1;
        end
    end

endmodule

// File: tb/tb_m14k_rf_init_seq.sv
// Bench for m14k_rf_init_seq: three instances (16, 2 and 1 shadow sets) share
// stimulus and are each compared every cycle against a write-index model.
module tb_m14k_rf_init_seq;

    logic        gclk = 1'b0;
    logic        greset;
    logic        init_req;
    logic        w_rfwrite;
    logic [8:0]  w_dest;
    logic [31:0] w_wrdata;

    logic [2:0]  wr_o;
    logic [8:0]  dest_o [0:2];
    logic [31:0] data_o [0:2];
    logic [2:0]  done_o;
    logic [2:0]  stall_o;
    logic [2:0]  err_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    int sets [0:2] = '{16, 2, 1};
    bit m_sweep [0:2];
    int m_idx   [0:2];
    bit m_err   [0:2];
    int nwr     [0:2];
    bit err_known = 1'b0;

    logic [31:0] rf_mem [0:511];

    typedef struct {
        logic        wv;
        logic [8:0]  d;
        logic [31:0] dat;
        logic        exp_wr;
        logic [8:0]  exp_dest;
        logic [31:0] exp_data;
        logic        exp_done;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [0:3];

    always #5 gclk = ~gclk;

    m14k_rf_init_seq #(.NUM_SETS(16)) u_dut16 (
        .gclk(gclk), .greset(greset), .init_req(init_req), .w_rfwrite(w_rfwrite),
        .w_dest(w_dest), .w_wrdata(w_wrdata), .mpc_rfwrite_w(wr_o[0]),
        .mpc_dest_w(dest_o[0]), .edp_wrdata_w(data_o[0]), .rf_init_done(done_o[0]),
        .init_stall(stall_o[0]), .init_wr_err(err_o[0])
    );

    m14k_rf_init_seq #(.NUM_SETS(2)) u_dut2 (
        .gclk(gclk), .greset(greset), .init_req(init_req), .w_rfwrite(w_rfwrite),
        .w_dest(w_dest), .w_wrdata(w_wrdata), .mpc_rfwrite_w(wr_o[1]),
        .mpc_dest_w(dest_o[1]), .edp_wrdata_w(data_o[1]), .rf_init_done(done_o[1]),
        .init_stall(stall_o[1]), .init_wr_err(err_o[1])
    );

    m14k_rf_init_seq #(.NUM_SETS(1)) u_dut1 (
        .gclk(gclk), .greset(greset), .init_req(init_req), .w_rfwrite(w_rfwrite),
        .w_dest(w_dest), .w_wrdata(w_wrdata), .mpc_rfwrite_w(wr_o[2]),
        .mpc_dest_w(dest_o[2]), .edp_wrdata_w(data_o[2]), .rf_init_done(done_o[2]),
        .init_stall(stall_o[2]), .init_wr_err(err_o[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow from the write index k of the running sweep:
    // write k lands on set k/31, register k%31+1.
    task automatic checkAll();
        for (int i = 0; i < 3; i++) begin
            logic        ewr;
            logic [8:0]  ed;
            logic [31:0] edat;
            logic        edone;
            logic        estall;
            if (greset) begin
                ewr = 1'b0; ed = 9'd0; edat = 32'd0; edone = 1'b0; estall = 1'b1;
            end else if (m_sweep[i]) begin
                ewr = 1'b1;
                ed = {4'(m_idx[i] / 31), 5'(m_idx[i] % 31 + 1)};
                edat = 32'd0; edone = 1'b0; estall = 1'b1;
            end else begin
                ewr = w_rfwrite; ed = w_dest; edat = w_wrdata; edone = 1'b1; estall = 1'b0;
            end
            checkOutput($sformatf("u%0d.wr", i), 32'(wr_o[i]), 32'(ewr));
            checkOutput($sformatf("u%0d.dest", i), 32'(dest_o[i]), 32'(ed));
            checkOutput($sformatf("u%0d.data", i), data_o[i], edat);
            checkOutput($sformatf("u%0d.done", i), 32'(done_o[i]), 32'(edone));
            checkOutput($sformatf("u%0d.stall", i), 32'(stall_o[i]), 32'(estall));
            if (err_known) begin
                checkOutput($sformatf("u%0d.err", i), 32'(err_o[i]), 32'(m_err[i]));
            end
            if (!greset && stall_o[i] && wr_o[i]) begin
                nwr[i]++;
            end
        end
        if (!greset && wr_o[0]) begin
            rf_mem[dest_o[0]] = data_o[0];
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            if (greset) begin
                m_sweep[i] = 1'b1; m_idx[i] = 0; m_err[i] = 1'b0; nwr[i] = 0;
            end else if (m_sweep[i]) begin
                if (w_rfwrite) begin
                    m_err[i] = 1'b1;
                end
                m_idx[i]++;
                if (m_idx[i] == sets[i] * 31) begin
                    m_sweep[i] = 1'b0;
                    checkOutput($sformatf("u%0d.sweep_len", i), 32'(nwr[i]), 32'(sets[i] * 31));
                end
            end else if (init_req) begin
                m_sweep[i] = 1'b1; m_idx[i] = 0; nwr[i] = 0;
            end
        end
        if (greset) begin
            err_known = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ir, input logic wv,
                                 input logic [8:0] d, input logic [31:0] dat);
        greset = r; init_req = ir; w_rfwrite = wv; w_dest = d; w_wrdata = dat;
        #1;
        checkAll();
    endtask

    task automatic stepClock();
        @(posedge gclk);
        modelStep();
        @(negedge gclk);
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
            stepClock();
        end
    endtask

    initial begin
        int nonzero;
        vecs[0] = '{1'b1, 9'h0A5, 32'hDEADBEEF, 1'b1, 9'h0A5, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 9'h1FF, 32'h0000_FFFF, 1'b0, 9'h1FF, 32'h0000_FFFF, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 9'h000, 32'hCAFE_F00D, 1'b1, 9'h000, 32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 9'h1E1, 32'h8000_0001, 1'b1, 9'h1E1, 32'h8000_0001, 1'b1, 1'b0};
        for (int a = 0; a < 512; a++) begin
            rf_mem[a] = 32'hA5A5_A5A5;
        end

        // Power-up: three reset cycles, then the full 496-write sweep.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
            stepClock();
        end
        for (int c = 0; c < 500; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
            if (c == 0)   checkOutput("pwr.first_dest", 32'(dest_o[0]), 32'h001);
            if (c == 30)  checkOutput("pwr.dest_01f", 32'(dest_o[0]), 32'h01F);
            if (c == 31)  checkOutput("pwr.dest_021", 32'(dest_o[0]), 32'h021);
            if (c == 495) checkOutput("pwr.last_dest", 32'(dest_o[0]), 32'h1FF);
            if (c == 496) checkOutput("pwr.done", 32'(done_o[0]), 32'd1);
            if (c == 31)  checkOutput("pwr.one_set_done", 32'(done_o[2]), 32'd1);
            stepClock();
        end
        nonzero = 0;
        for (int s = 0; s < 16; s++) begin
            for (int r = 1; r < 32; r++) begin
                if (rf_mem[s * 32 + r] !== 32'd0) nonzero++;
            end
        end
        checkOutput("pwr.rf_nonzero", 32'(nonzero), 32'd0);

        // Pass-through table in DONE.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(1'b0, 1'b0, vecs[v].wv, vecs[v].d, vecs[v].dat);
            checkOutput($sformatf("vec%0d.wr", v), 32'(wr_o[0]), 32'(vecs[v].exp_wr));
            checkOutput($sformatf("vec%0d.dest", v), 32'(dest_o[0]), 32'(vecs[v].exp_dest));
            checkOutput($sformatf("vec%0d.data", v), data_o[0], vecs[v].exp_data);
            checkOutput($sformatf("vec%0d.done", v), 32'(done_o[0]), 32'(vecs[v].exp_done));
            checkOutput($sformatf("vec%0d.stall", v), 32'(stall_o[0]), 32'(vecs[v].exp_stall));
            stepClock();
        end

        // Re-sweep on request with extra requests arriving mid-sweep.
        applyStimulus(1'b0, 1'b1, 1'b1, 9'h044, 32'h1111_2222);
        checkOutput("req.passthru", 32'(dest_o[1]), 32'h044);
        stepClock();
        for (int c = 0; c < 500; c++) begin
            applyStimulus(1'b0, (c == 20 || c == 40), 1'b0, 9'd0, 32'd0);
            if (c == 0)  checkOutput("req.stall", 32'(stall_o[1]), 32'd1);
            if (c == 32) checkOutput("req.set1_dest", 32'(dest_o[1]), 32'h022);
            if (c == 62) checkOutput("req.u2_done", 32'(done_o[1]), 32'd1);
            stepClock();
        end

        // Collision at sweep write 10.
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd0, 32'd0);
        stepClock();
        for (int c = 0; c < 500; c++) begin
            if (c == 10) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 9'h003, 32'h1234_5678);
                checkOutput("coll.dest", 32'(dest_o[0]), 32'h00B);
                checkOutput("coll.data", data_o[0], 32'd0);
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
            end
            if (c == 11)  checkOutput("coll.err", 32'(err_o[0]), 32'd1);
            if (c == 499) checkOutput("coll.err_sticky", 32'(err_o[0]), 32'd1);
            stepClock();
        end

        // Reset pulse at sweep write 200.
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd0, 32'd0);
        stepClock();
        idleCycles(200);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("rst.wr_off", 32'(wr_o[0]), 32'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("rst.restart_dest", 32'(dest_o[0]), 32'h001);
        checkOutput("rst.err_clear", 32'(err_o[0]), 32'd0);
        stepClock();
        idleCycles(496);

        // Randomized traffic, requests and occasional resets.
        for (int c = 0; c < 2500; c++) begin
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
                          1'($urandom), 9'($urandom), $urandom);
            stepClock();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
